// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity selectors and the
// baud divider helper used by both tx and rx engines.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clocks per bit, truncated toward zero.
  function automatic int calc_div(input longint clk_freq, input longint baud);
    return int'(clk_freq / baud);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..DIV-1 while enabled and flags the last clock of each
// bit period. A clear restarts the period at 0.
module uart_baud_gen #(
  parameter int DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign o_tick = i_en && (r_count == LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// Parametrised UART transmitter (start, DATA_BITS LSB first, optional parity, 1/2 stop).
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry queue in front of the serialiser.
//
// Handshake: a word moves on a rising edge where i_tx_valid and o_tx_ready are both 1;
// i_tx_data is only looked at on that edge, and o_tx_ready never depends on i_tx_valid.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_tx_valid,
  input  logic [DATA_BITS-1:0]          i_tx_data,
  output logic                          o_tx_ready,
  output logic                          o_tx_busy,
  output logic                          o_tx_done,
  output logic                          o_tx_pin_out,
`ifdef UART_TX_FIFO_EN
  output logic [$clog2(FIFO_DEPTH):0]   o_tx_fifo_count,
`endif
  output logic [2:0]                    o_dbg_state
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int BIW = 4;
  localparam logic [BIW-1:0] LAST_BIT = BIW'(DATA_BITS - 1);
  localparam logic HAS_PAR  = (PARITY != PAR_NONE);
  localparam logic TWO_STOP = (STOP_BITS == 2);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_engine: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_engine: DATA_BITS must be 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_engine: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_engine: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_engine: FIFO_DEPTH must be a power of 2, at least 2");
  end

  tx_state_t            r_state;
  tx_state_t            w_next;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic [BIW-1:0]       r_bit_idx;
  logic                 r_stop_idx;
  logic                 r_rdy_en;
  logic                 w_tick;
  logic                 w_load;
  logic                 w_done;
  logic [DATA_BITS-1:0] w_load_data;

  assign w_done = (r_state == TX_STOP) && w_tick && (r_stop_idx == TWO_STOP);

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 w_full;
  logic                 w_push;

  assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
  assign o_tx_ready  = r_rdy_en && !w_full;
  assign w_push      = i_tx_valid && o_tx_ready;
  // Popping in the tx_done cycle lets queued frames follow with no idle bit.
  assign w_load      = r_rdy_en && (r_count != '0) && ((r_state == TX_IDLE) || w_done);
  assign w_load_data = r_mem[r_rd_ptr];
  assign o_tx_fifo_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_tx_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  assign o_tx_ready  = r_rdy_en && (r_state == TX_IDLE);
  assign w_load      = i_tx_valid && o_tx_ready;
  assign w_load_data = i_tx_data;
`endif

  uart_baud_gen #(
    .DIV(DIV)
  ) u_baud (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_load),
    .i_en  (r_state != TX_IDLE),
    .o_tick(w_tick)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= TX_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      TX_IDLE:   if (w_load) w_next = TX_START;
      TX_START:  if (w_tick) w_next = TX_DATA;
      TX_DATA:   if (w_tick && (r_bit_idx == LAST_BIT)) w_next = HAS_PAR ? TX_PARITY : TX_STOP;
      TX_PARITY: if (w_tick) w_next = TX_STOP;
      TX_STOP:   if (w_done) w_next = w_load ? TX_START : TX_IDLE;
      default:   w_next = TX_IDLE;
    endcase
  end

  always_comb begin
    o_tx_pin_out = 1'b1;
    case (r_state)
      TX_START:  o_tx_pin_out = 1'b0;
      TX_DATA:   o_tx_pin_out = r_shift[0];
      TX_PARITY: o_tx_pin_out = r_par;
      default:   o_tx_pin_out = 1'b1;
    endcase
  end

  // r_rdy_en keeps ready low for the first clock after reset is released.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_rdy_en   <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_load) begin
        r_shift    <= w_load_data;
        r_par      <= (PARITY == PAR_EVEN) ? ^w_load_data : ~^w_load_data;
        r_bit_idx  <= '0;
        r_stop_idx <= 1'b0;
      end else if (w_tick) begin
        if (r_state == TX_DATA) begin
          r_shift   <= r_shift >> 1;
          r_bit_idx <= r_bit_idx + 1'b1;
        end
        if (r_state == TX_STOP) begin
          r_stop_idx <= ~r_stop_idx;
        end
      end
    end
  end

  assign o_tx_busy   = (r_state != TX_IDLE);
  assign o_tx_done   = w_done;
  assign o_dbg_state = r_state;

endmodule
